// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding for NUM_SRC sources, load-use hazard detection with a
// LOAD_LAT-cycle stall FSM, and saturating forward/stall event counters.
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_SRC*REG_AW-1:0]   ifid_rs_i,
    input  logic [NUM_SRC-1:0]          ifid_rs_used_i,
    input  logic [NUM_SRC*REG_AW-1:0]   idex_rs_i,
    input  logic [REG_AW-1:0]           idex_rd_i,
    input  logic                        idex_memread_i,
    input  logic [REG_AW-1:0]           exmem_rd_i,
    input  logic                        exmem_regwrite_i,
    input  logic [REG_AW-1:0]           memwb_rd_i,
    input  logic                        memwb_regwrite_i,
    input  logic                        flush_i,
    input  logic                        clr_cnt_i,
    output logic [NUM_SRC*2-1:0]        fwd_sel_o,
    output logic                        stall_o,
    output logic                        bubble_o,
    output logic [CNT_W-1:0]            fwd_cnt_o,
    output logic [CNT_W-1:0]            stall_cnt_o,
    output logic                        dbg_state_o
);

    localparam int REM_W = $clog2(LOAD_LAT + 1);
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_LAT - 1);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [REM_W-1:0]       rem_q, rem_d;
    logic [NUM_SRC*2-1:0]   fwd_sel;
    logic                   rs_match;
    logic                   hz;
    logic                   stall_int;
    logic                   any_fwd;

    // Youngest producer (EX/MEM) wins; each stage zero-checks its own destination.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (exmem_regwrite_i && exmem_rd_i != '0 &&
                idex_rs_i[i*REG_AW +: REG_AW] == exmem_rd_i)
                fwd_sel[i*2 +: 2] = 2'b10;
            else if (memwb_regwrite_i && memwb_rd_i != '0 &&
                     idex_rs_i[i*REG_AW +: REG_AW] == memwb_rd_i)
                fwd_sel[i*2 +: 2] = 2'b01;
        end
    end

    always_comb begin
        rs_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ifid_rs_used_i[i] && ifid_rs_i[i*REG_AW +: REG_AW] == idex_rd_i)
                rs_match = 1'b1;
        end
        hz = idex_memread_i && (idex_rd_i != '0) && rs_match;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // In STALL the ID/EX stage already holds a bubble, so hz is not re-evaluated.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        stall_int = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hz) begin
                        stall_int = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = STALL;
                            rem_d   = REM_INIT;
                        end
                    end
                end
                STALL: begin
                    stall_int = 1'b1;
                    rem_d     = rem_q - REM_ONE;
                    if (rem_q == REM_ONE)
                        state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            endcase
        end
    end

    assign fwd_sel_o   = rst_i ? '0 : fwd_sel;
    assign stall_o     = stall_int && !rst_i;
    assign bubble_o    = stall_int && !rst_i;
    assign any_fwd     = |fwd_sel_o;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fwd_cnt_o   <= '0;
            stall_cnt_o <= '0;
        end else if (clr_cnt_i) begin
            fwd_cnt_o   <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (any_fwd && fwd_cnt_o != CNT_MAX)
                fwd_cnt_o <= fwd_cnt_o + 1'b1;
            if (stall_o && stall_cnt_o != CNT_MAX)
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: three instances (LOAD_LAT=1, LOAD_LAT=3, CNT_W=4) share stimulus;
// the driver queues hand-computed expectations, a negedge monitor pops and compares them.
module tb_fwd_hazard_unit;

    localparam int EW = 39;  // {fwd[3:0], stall, bubble, fwd_cnt[15:0], stall_cnt[15:0], state}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  ifid_rs;
    logic [1:0]  ifid_used;
    logic [9:0]  idex_rs;
    logic [4:0]  idex_rd;
    logic        idex_memread;
    logic [4:0]  exmem_rd;
    logic        exmem_rw;
    logic [4:0]  memwb_rd;
    logic        memwb_rw;
    logic        flush;
    logic        clr;

    logic [3:0]  fwd_a, fwd_b, fwd_c;
    logic        stall_a, stall_b, stall_c;
    logic        bub_a, bub_b, bub_c;
    logic [15:0] fc_a, sc_a, fc_b, sc_b;
    logic [3:0]  fc_c, sc_c;
    logic        st_a, st_b, st_c;

    logic [EW-1:0] exp_q[$];
    int            dut_q[$];
    int            tag_q[$];
    int            checks   = 0;
    int            failures = 0;
    int            tag      = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_i(rst), .ifid_rs_i(ifid_rs), .ifid_rs_used_i(ifid_used),
        .idex_rs_i(idex_rs), .idex_rd_i(idex_rd), .idex_memread_i(idex_memread),
        .exmem_rd_i(exmem_rd), .exmem_regwrite_i(exmem_rw), .memwb_rd_i(memwb_rd),
        .memwb_regwrite_i(memwb_rw), .flush_i(flush), .clr_cnt_i(clr),
        .fwd_sel_o(fwd_a), .stall_o(stall_a), .bubble_o(bub_a),
        .fwd_cnt_o(fc_a), .stall_cnt_o(sc_a), .dbg_state_o(st_a));

    fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(16)) u_b (
        .clk_i(clk), .rst_i(rst), .ifid_rs_i(ifid_rs), .ifid_rs_used_i(ifid_used),
        .idex_rs_i(idex_rs), .idex_rd_i(idex_rd), .idex_memread_i(idex_memread),
        .exmem_rd_i(exmem_rd), .exmem_regwrite_i(exmem_rw), .memwb_rd_i(memwb_rd),
        .memwb_regwrite_i(memwb_rw), .flush_i(flush), .clr_cnt_i(clr),
        .fwd_sel_o(fwd_b), .stall_o(stall_b), .bubble_o(bub_b),
        .fwd_cnt_o(fc_b), .stall_cnt_o(sc_b), .dbg_state_o(st_b));

    fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(4)) u_c (
        .clk_i(clk), .rst_i(rst), .ifid_rs_i(ifid_rs), .ifid_rs_used_i(ifid_used),
        .idex_rs_i(idex_rs), .idex_rd_i(idex_rd), .idex_memread_i(idex_memread),
        .exmem_rd_i(exmem_rd), .exmem_regwrite_i(exmem_rw), .memwb_rd_i(memwb_rd),
        .memwb_regwrite_i(memwb_rw), .flush_i(flush), .clr_cnt_i(clr),
        .fwd_sel_o(fwd_c), .stall_o(stall_c), .bubble_o(bub_c),
        .fwd_cnt_o(fc_c), .stall_cnt_o(sc_c), .dbg_state_o(st_c));

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        ifid_rs      = '0;
        ifid_used    = '0;
        idex_rs      = '0;
        idex_rd      = '0;
        idex_memread = 1'b0;
        exmem_rd     = '0;
        exmem_rw     = 1'b0;
        memwb_rd     = '0;
        memwb_rw     = 1'b0;
        flush        = 1'b0;
        clr          = 1'b0;
    endtask

    task automatic set_hazard(input logic [1:0] used);
        idex_memread = 1'b1;
        idex_rd      = 5'd4;
        ifid_rs      = {5'd0, 5'd4};
        ifid_used    = used;
    endtask

    task automatic expect_out(input int dut, input logic [3:0] fwd, input logic stall,
                              input int fc, input int sc, input logic st);
        logic [15:0] fc16;
        logic [15:0] sc16;
        fc16 = fc[15:0];
        sc16 = sc[15:0];
        exp_q.push_back({fwd, stall, stall, fc16, sc16, st});
        dut_q.push_back(dut);
        tag_q.push_back(tag);
        tag++;
    endtask

    // Reset asserted with live forward/hazard inputs: every instance must show zeros.
    task automatic do_reset();
        next_cycle();
        rst      = 1'b1;
        set_idle();
        idex_rs  = {5'd5, 5'd3};
        exmem_rd = 5'd3;
        exmem_rw = 1'b1;
        memwb_rd = 5'd5;
        memwb_rw = 1'b1;
        set_hazard(2'b01);
        for (int d = 0; d < 3; d++) expect_out(d, 4'b0000, 1'b0, 0, 0, 1'b0);
        next_cycle();
        rst = 1'b0;
        set_idle();
        for (int d = 0; d < 3; d++) expect_out(d, 4'b0000, 1'b0, 0, 0, 1'b0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] act;
        int            d;
        int            t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            d = dut_q.pop_front();
            t = tag_q.pop_front();
            case (d)
                0:       act = {fwd_a, stall_a, bub_a, fc_a, sc_a, st_a};
                1:       act = {fwd_b, stall_b, bub_b, fc_b, sc_b, st_b};
                default: act = {fwd_c, stall_c, bub_c, 12'd0, fc_c, 12'd0, sc_c, st_c};
            endcase
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL vec%0d dut%0d: got fwd=%b stall=%b bub=%b fcnt=%0d scnt=%0d st=%b, want fwd=%b stall=%b bub=%b fcnt=%0d scnt=%0d st=%b",
                         t, d, act[38:35], act[34], act[33], act[32:17], act[16:1], act[0],
                         e[38:35], e[34], e[33], e[32:17], e[16:1], e[0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Phase A: forwarding and single-cycle load-use stall (u_a, LOAD_LAT=1)
        do_reset();
        next_cycle(); idex_rs = {5'd5, 5'd3}; exmem_rd = 5'd3; exmem_rw = 1'b1;
                      memwb_rd = 5'd5; memwb_rw = 1'b1;
                      expect_out(0, 4'b0110, 1'b0, 0, 0, 1'b0);
        next_cycle(); expect_out(0, 4'b0110, 1'b0, 1, 0, 1'b0);
        next_cycle(); set_idle(); expect_out(0, 4'b0000, 1'b0, 2, 0, 1'b0);
        next_cycle(); exmem_rd = 5'd7; exmem_rw = 1'b1; memwb_rd = 5'd7; memwb_rw = 1'b1;
                      idex_rs = {5'd0, 5'd7};
                      expect_out(0, 4'b0010, 1'b0, 2, 0, 1'b0);
        next_cycle(); exmem_rw = 1'b0; expect_out(0, 4'b0001, 1'b0, 3, 0, 1'b0);
        next_cycle(); memwb_rd = 5'd0; idex_rs = '0; expect_out(0, 4'b0000, 1'b0, 4, 0, 1'b0);
        next_cycle(); exmem_rd = 5'd0; exmem_rw = 1'b1; memwb_rd = 5'd7; memwb_rw = 1'b1;
                      idex_rs = {5'd0, 5'd7};
                      expect_out(0, 4'b0001, 1'b0, 4, 0, 1'b0);
        next_cycle(); set_idle(); expect_out(0, 4'b0000, 1'b0, 5, 0, 1'b0);
        next_cycle(); set_hazard(2'b01); expect_out(0, 4'b0000, 1'b1, 5, 0, 1'b0);
        next_cycle(); set_idle(); expect_out(0, 4'b0000, 1'b0, 5, 1, 1'b0);
        next_cycle(); set_hazard(2'b00); expect_out(0, 4'b0000, 1'b0, 5, 1, 1'b0);
        next_cycle(); set_idle(); expect_out(0, 4'b0000, 1'b0, 5, 1, 1'b0);
        next_cycle(); set_hazard(2'b10); ifid_rs = {5'd4, 5'd0};
                      expect_out(0, 4'b0000, 1'b1, 5, 1, 1'b0);
        next_cycle(); set_idle(); expect_out(0, 4'b0000, 1'b0, 5, 2, 1'b0);
        next_cycle(); idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs = '0; ifid_used = 2'b01;
                      expect_out(0, 4'b0000, 1'b0, 5, 2, 1'b0);

        // Phase B: multi-cycle stall, flush and reset mid-stall (u_b, LOAD_LAT=3)
        do_reset();
        next_cycle(); set_hazard(2'b01); expect_out(1, 4'b0000, 1'b1, 0, 0, 1'b0);
        next_cycle(); set_idle(); expect_out(1, 4'b0000, 1'b1, 0, 1, 1'b1);
        next_cycle(); expect_out(1, 4'b0000, 1'b1, 0, 2, 1'b1);
        next_cycle(); expect_out(1, 4'b0000, 1'b0, 0, 3, 1'b0);
        next_cycle(); expect_out(1, 4'b0000, 1'b0, 0, 3, 1'b0);
        next_cycle(); set_hazard(2'b01); expect_out(1, 4'b0000, 1'b1, 0, 3, 1'b0);
        next_cycle(); set_idle(); flush = 1'b1; expect_out(1, 4'b0000, 1'b0, 0, 4, 1'b1);
        next_cycle(); flush = 1'b0; expect_out(1, 4'b0000, 1'b0, 0, 4, 1'b0);
        // hazard held through the stall window; re-detected on the return to IDLE
        next_cycle(); set_hazard(2'b01); expect_out(1, 4'b0000, 1'b1, 0, 4, 1'b0);
        next_cycle(); expect_out(1, 4'b0000, 1'b1, 0, 5, 1'b1);
        next_cycle(); expect_out(1, 4'b0000, 1'b1, 0, 6, 1'b1);
        next_cycle(); expect_out(1, 4'b0000, 1'b1, 0, 7, 1'b0);
        next_cycle(); set_idle(); expect_out(1, 4'b0000, 1'b1, 0, 8, 1'b1);
        next_cycle(); expect_out(1, 4'b0000, 1'b1, 0, 9, 1'b1);
        next_cycle(); expect_out(1, 4'b0000, 1'b0, 0, 10, 1'b0);
        next_cycle(); set_hazard(2'b01); flush = 1'b1; expect_out(1, 4'b0000, 1'b0, 0, 10, 1'b0);
        next_cycle(); set_idle(); expect_out(1, 4'b0000, 1'b0, 0, 10, 1'b0);
        next_cycle(); set_hazard(2'b01); expect_out(1, 4'b0000, 1'b1, 0, 10, 1'b0);
        next_cycle(); set_idle(); rst = 1'b1; expect_out(1, 4'b0000, 1'b0, 0, 0, 1'b0);
        next_cycle(); rst = 1'b0; expect_out(1, 4'b0000, 1'b0, 0, 0, 1'b0);
        next_cycle(); expect_out(1, 4'b0000, 1'b0, 0, 0, 1'b0);

        // Phase C: counter saturation and clear (u_c, CNT_W=4)
        do_reset();
        next_cycle();
        idex_rs  = {5'd0, 5'd3};
        exmem_rd = 5'd3;
        exmem_rw = 1'b1;
        for (int k = 0; k < 20; k++) begin
            expect_out(2, 4'b0010, 1'b0, (k < 15) ? k : 15, 0, 1'b0);
            next_cycle();
        end
        clr = 1'b1; expect_out(2, 4'b0010, 1'b0, 15, 0, 1'b0);
        next_cycle(); clr = 1'b0; expect_out(2, 4'b0010, 1'b0, 0, 0, 1'b0);
        next_cycle(); expect_out(2, 4'b0010, 1'b0, 1, 0, 1'b0);

        // drain the scoreboard with a bounded wait
        for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got pending=%0d, want pending=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor of the 2-operand forwarding unit. Combines N-source EX-stage operand forwarding with load-use hazard detection and a multi-cycle stall FSM.
- Adds saturating forward/stall event counters for performance measurement.
- Sits beside the ID/EX pipeline register. Drives ALU operand muxes, PC/IF-ID write-enables and the ID/EX bubble insert.

Parameters:
- REG_AW, 5, register-address width.
- NUM_SRC, 2, source operands per instruction (1..4).
- LOAD_LAT, 1, stall cycles per load-use hazard (1..8).
- CNT_W, 16, event counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- ifid_rs_i  in  NUM_SRC*REG_AW  ID-stage source regs; src i at [i*REG_AW +: REG_AW].
- ifid_rs_used_i  in  NUM_SRC  per-source "operand read" flag.
- idex_rs_i  in  NUM_SRC*REG_AW  EX-stage source regs.
- idex_rd_i  in  REG_AW  EX-stage destination.
- idex_memread_i  in  1  EX-stage instruction is a load.
- exmem_rd_i  in  REG_AW  MEM-stage destination.
- exmem_regwrite_i  in  1  MEM-stage writes the register file.
- memwb_rd_i  in  REG_AW  WB-stage destination.
- memwb_regwrite_i  in  1  WB-stage writes the register file.
- flush_i  in  1  branch/jump flush.
- clr_cnt_i  in  1  synchronous counter clear.
- fwd_sel_o  out  NUM_SRC*2  per-source mux select. 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- stall_o  out  1  hold PC and IF/ID.
- bubble_o  out  1  zero ID/EX control this cycle.
- fwd_cnt_o  out  CNT_W  cycles with any forward.
- stall_cnt_o  out  CNT_W  cycles with stall_o=1.

Behaviour:
- Reset (async, rst_i=1): state IDLE, remaining-cycle count 0, both counters 0. fwd_sel_o, stall_o and bubble_o are forced to 0 while rst_i=1.
- Forwarding is combinational with zero latency. It is evaluated independently for each source i:
  - 10 if exmem_regwrite_i && exmem_rd_i!=0 && idex_rs[i]==exmem_rd_i.
  - else 01 if memwb_regwrite_i && memwb_rd_i!=0 && idex_rs[i]==memwb_rd_i.
  - else 00.
  - The MEM/WB zero-check uses memwb_rd_i; it never uses exmem_rd_i.
- EX/MEM has priority when both stages match (youngest producer wins).
- Load-use hazard (hz): idex_memread_i && idex_rd_i!=0 && there exists i with ifid_rs_used_i[i] && ifid_rs[i]==idex_rd_i.
- FSM states are IDLE and STALL. A remaining-cycle counter rem is ceil(log2(LOAD_LAT+1)) bits.
- IDLE:
  - stall_o = bubble_o = hz && !flush_i.
  - On hz && !flush_i && LOAD_LAT>1: next state STALL, rem <= LOAD_LAT-1.
  - Otherwise stay in IDLE.
  - With LOAD_LAT=1, exactly one stall cycle per hazard and no STALL entry.
- STALL:
  - stall_o = bubble_o = !flush_i. hz is ignored, because ID/EX holds a bubble.
  - rem decrements each cycle. When rem==1, next state is IDLE.
  - Total stall cycles per hazard = LOAD_LAT.
- flush_i has priority in any state: stall_o=bubble_o=0 that cycle, next state IDLE, rem <= 0.
- Counters:
  - fwd_cnt_o increments in a cycle where any fwd_sel_o field !=00.
  - stall_cnt_o increments in a cycle where stall_o=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - clr_cnt_i zeroes both next edge and overrides increment in the same cycle.
  - Counters update on rising edge; outputs are registered values.
- A hazard arriving in the cycle STALL returns to IDLE is detected normally in IDLE on the following cycle.
- Reset mid-STALL: immediate return to IDLE, outputs 0, counters 0.

Test Plan:
- NUM_SRC=2. idex_rs={5,3}, exmem_rd=3/regwrite=1, memwb_rd=5/regwrite=1 -> fwd_sel_o=4'b01_10 (src1=01, src0=10); fwd_cnt_o +1 next edge.
- exmem_rd=memwb_rd=7, both regwrite=1, idex_rs0=7 -> src0=10. Then exmem_regwrite=0 -> src0=01. Then memwb_rd=0, idex_rs0=0 -> src0=00.
- LOAD_LAT=1. idex_memread=1, idex_rd=4, ifid_rs0=4, rs_used=2'b01 -> stall_o=bubble_o=1 for exactly 1 cycle; stall_cnt_o=1. Same case with rs_used=2'b00 -> no stall.
- LOAD_LAT=3, same hazard held for one cycle -> stall_o high for exactly 3 consecutive cycles, then 0; stall_cnt_o=3.
- LOAD_LAT=3, flush_i=1 on 2nd stall cycle -> stall_o=0 that cycle, IDLE next; stall_cnt_o=1. Separately, assert rst_i mid-STALL -> outputs 0 immediately, counters 0.
- CNT_W=4. Force a forward for 20 cycles -> fwd_cnt_o saturates at 15. Then assert clr_cnt_i with forward still active -> fwd_cnt_o=0 next edge.
